// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for the single-ported data memory.
//   Master 0 = core load/store path, master 1 = boot loader / debug port.
//   One access is granted per cycle. A master can lock the grant for
//   back-to-back ownership. Synchronous-RAM read data is returned with a
//   1-cycle rvalid to the master that issued the read.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-break in IDLE;
//   leave it undefined for fixed priority (master 0 wins ties).
// Ports:
//   clk, reset (async, active-low)
//   mK_req/we/lock/addr/wdata  -> master K request (K = 0,1)
//   mK_gnt                     <- access accepted this cycle (combinational)
//   mK_rvalid/rdata            <- read return, one cycle after a read grant
//   mem_en/we/addr/wdata       -> memory strobe and granted master's payload
//   mem_rdata                  <- synchronous RAM read data
module dmem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOCK0 = 2'd1;
  localparam logic [1:0] S_LOCK1 = 2'd2;

`ifdef DMEM_ARB_RR_EN
  localparam logic FIXED_PRIO = 1'b0;
`else
  localparam logic FIXED_PRIO = 1'b1;
`endif

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_last_gnt;
  logic       r_rd_pend;
  logic       r_rd_own;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_tie_m0;
  logic       w_any_gnt;
  logic       w_rd_gnt;

  // Tie winner in IDLE: master 0 unless round-robin says master 1 is due
  assign w_tie_m0 = FIXED_PRIO | r_last_gnt;

  // Grant and next-state decode
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_LOCK0: begin
        w_gnt0 = m0_req;
        if (!(m0_req && m0_lock)) w_state_nxt = S_IDLE;
      end
      S_LOCK1: begin
        w_gnt1 = m1_req;
        if (!(m1_req && m1_lock)) w_state_nxt = S_IDLE;
      end
      default: begin
        if (m0_req && m1_req) begin
          w_gnt0 = w_tie_m0;
          w_gnt1 = ~w_tie_m0;
        end else begin
          w_gnt0 = m0_req;
          w_gnt1 = m1_req;
        end
        if (w_gnt0 && m0_lock)      w_state_nxt = S_LOCK0;
        else if (w_gnt1 && m1_lock) w_state_nxt = S_LOCK1;
        else                        w_state_nxt = S_IDLE;
      end
    endcase
    // No grant may leak out while reset is held
    if (!reset) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_any_gnt = w_gnt0 | w_gnt1;
  assign w_rd_gnt  = (w_gnt0 & ~m0_we) | (w_gnt1 & ~m1_we);

  // Arbitration state and read-return tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;
      r_rd_pend  <= 1'b0;
      r_rd_own   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_rd_gnt;
      if (w_any_gnt) r_last_gnt <= w_gnt1;
      if (w_rd_gnt)  r_rd_own   <= w_gnt1;
    end
  end

  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;

  // Memory port mux; idle bus drives zeros
  assign mem_en    = w_any_gnt;
  assign mem_we    = (w_gnt0 & m0_we) | (w_gnt1 & m1_we);
  assign mem_addr  = w_gnt0 ? m0_addr  : (w_gnt1 ? m1_addr  : AW'(0));
  assign mem_wdata = w_gnt0 ? m0_wdata : (w_gnt1 ? m1_wdata : DW'(0));

  // Shared read data, qualified per master by rvalid
  assign m0_rvalid = r_rd_pend & ~r_rd_own;
  assign m1_rvalid = r_rd_pend & r_rd_own;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus randomized traffic for
// dmem_arbiter, with a synchronous RAM and a transaction-level reference model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous RAM behind the arbiter (256 words, word-addressed by addr[9:2])
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  typedef struct {
    logic        rst;
    logic        rst_mid;
    logic        r0, w0, l0;
    logic [31:0] a0, d0;
    logic        r1, w1, l1;
    logic [31:0] a1, d1;
    logic        eg0, eg1, ev0, ev1;
    logic [31:0] erd;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: lock owner (-1 none), last winner, one pending read
  int          m_lock;
  int          m_last;
  bit          m_pend;
  int          m_own;
  logic [31:0] m_data;
  logic [31:0] ref_mem [256];

  function automatic vec_t mk(input logic rst,
                              input logic r0, input logic w0, input logic l0,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic r1, input logic w1, input logic l1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic eg0, input logic eg1,
                              input logic ev0, input logic ev1,
                              input logic [31:0] erd);
    vec_t v;
    v.rst = rst; v.rst_mid = 1'b0;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1; v.erd = erd;
    return v;
  endfunction

  function automatic vec_t idle(input logic ev0, input logic ev1, input logic [31:0] erd);
    return mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0,ev0,ev1,erd);
  endfunction

  task automatic model_reset();
    m_lock = -1;
    m_last = 1;
    m_pend = 1'b0;
    m_own  = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance model
  task automatic step(input vec_t v, input bit hand);
    logic        g0, g1, ev0, ev1, ewe, k, we;
    logic [31:0] ea, ed;
    @(negedge clk);
    reset = v.rst;
    m0_req = v.r0; m0_we = v.w0; m0_lock = v.l0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_lock = v.l1; m1_addr = v.a1; m1_wdata = v.d1;
    #1;
    if (!v.rst) model_reset();
    g0 = 1'b0;
    g1 = 1'b0;
    if (v.rst) begin
      if (m_lock == 0)            g0 = v.r0;
      else if (m_lock == 1)       g1 = v.r1;
      else if (v.r0 && v.r1) begin
        if (RR && m_last == 0)    g1 = 1'b1;
        else                      g0 = 1'b1;
      end else begin
        g0 = v.r0;
        g1 = v.r1;
      end
    end
    ev0 = m_pend && (m_own == 0);
    ev1 = m_pend && (m_own == 1);
    ewe = g0 ? v.w0 : (g1 ? v.w1 : 1'b0);
    ea  = g0 ? v.a0 : (g1 ? v.a1 : 32'h0);
    ed  = g0 ? v.d0 : (g1 ? v.d1 : 32'h0);

    chk("m0_gnt", 32'(m0_gnt), 32'(g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(g1));
    chk("mem_en", 32'(mem_en), 32'(g0 | g1));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
    if (ev0) chk("m0_rdata", m0_rdata, m_data);
    if (ev1) chk("m1_rdata", m1_rdata, m_data);
    if (hand) begin
      chk("vec_m0_gnt", 32'(m0_gnt), 32'(v.eg0));
      chk("vec_m1_gnt", 32'(m1_gnt), 32'(v.eg1));
      chk("vec_m0_rvalid", 32'(m0_rvalid), 32'(v.ev0));
      chk("vec_m1_rvalid", 32'(m1_rvalid), 32'(v.ev1));
      if (v.ev0) chk("vec_m0_rdata", m0_rdata, v.erd);
      if (v.ev1) chk("vec_m1_rdata", m1_rdata, v.erd);
    end

    if (v.rst_mid) begin
      #1 reset = 1'b0;
      model_reset();
    end else if (v.rst) begin
      // Advance model by the accepted transaction, if any
      m_pend = 1'b0;
      if (g0 || g1) begin
        k  = g1;
        we = g1 ? v.w1 : v.w0;
        if (we) ref_mem[ea[9:2]] = ed;
        else    m_data = ref_mem[ea[9:2]];
        m_pend = !we;
        m_own  = int'(k);
        m_last = int'(k);
      end
      if (m_lock < 0) begin
        if (g0 && v.l0)      m_lock = 0;
        else if (g1 && v.l1) m_lock = 1;
      end else if (m_lock == 0) begin
        if (!(v.r0 && v.l0)) m_lock = -1;
      end else begin
        if (!(v.r1 && v.l1)) m_lock = -1;
      end
    end
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    model_reset();

    // Reset held with requests pending: nothing may be granted
    tbl.push_back(mk(0, 1,1,0,32'h100,32'h1, 1,1,0,32'h200,32'h2, 0,0,0,0,0));
    tbl.push_back(mk(0, 1,0,1,32'h100,32'h1, 1,0,1,32'h200,32'h2, 0,0,0,0,0));
    // Single master write then read back; m1 write overlaps the rvalid
    tbl.push_back(mk(1, 1,1,0,32'h100,32'hDEADBEEF, 0,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1, 1,0,0,32'h100,32'h0, 0,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 1,1,0,32'h200,32'hCAFEF00D, 0,1,1,0,32'hDEADBEEF));
    tbl.push_back(idle(0,0,0));
    // Tie from reset release
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    if (RR) begin
      tbl.push_back(mk(1, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 1,0,0,0,0));
      tbl.push_back(mk(1, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 0,1,1,0,32'hDEADBEEF));
      tbl.push_back(mk(1, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 1,0,0,1,32'hCAFEF00D));
      tbl.push_back(mk(1, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 0,1,1,0,32'hDEADBEEF));
      tbl.push_back(idle(0,1,32'hCAFEF00D));
    end else begin
      tbl.push_back(mk(1, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 1,0,0,0,0));
      for (int i = 0; i < 3; i++)
        tbl.push_back(mk(1, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 1,0,1,0,32'hDEADBEEF));
      tbl.push_back(idle(1,0,32'hDEADBEEF));
    end
    // m1 locks, m0 requests throughout; unlock access granted, then m0
    tbl.push_back(mk(1, 0,0,0,0,0, 1,1,1,32'h300,32'h11, 0,1,0,0,0));
    tbl.push_back(mk(1, 1,0,0,32'h100,0, 1,1,1,32'h304,32'h22, 0,1,0,0,0));
    tbl.push_back(mk(1, 1,0,0,32'h100,0, 1,1,1,32'h308,32'h33, 0,1,0,0,0));
    tbl.push_back(mk(1, 1,0,0,32'h100,0, 1,1,0,32'h30C,32'h44, 0,1,0,0,0));
    tbl.push_back(mk(1, 1,0,0,32'h100,0, 1,0,0,32'h300,0, 1,0,0,0,0));
    tbl.push_back(idle(1,0,32'hDEADBEEF));
    // m0 lock released by dropping req
    tbl.push_back(mk(1, 1,0,1,32'h100,0, 0,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 1,0,0,32'h200,0, 0,0,1,0,32'hDEADBEEF));
    tbl.push_back(mk(1, 0,0,0,0,0, 1,0,0,32'h200,0, 0,1,0,0,0));
    tbl.push_back(idle(0,1,32'hCAFEF00D));
    // Reset lands mid-read, before the capturing edge
    v = mk(1, 1,0,0,32'h100,0, 0,0,0,0,0, 1,0,0,0,0);
    v.rst_mid = 1'b1;
    tbl.push_back(v);
    tbl.push_back(mk(0, 1,0,0,32'h100,0, 1,0,0,32'h200,0, 0,0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 1,0,0,32'h200,0, 0,1,0,0,0));
    tbl.push_back(idle(0,1,32'hCAFEF00D));
    // Idle bus for 10 cycles, then a tie proves arbitration is in IDLE
    for (int i = 0; i < 10; i++) tbl.push_back(idle(0,0,0));
    tbl.push_back(mk(1, 1,1,0,32'h10,32'h55, 1,1,0,32'h20,32'h66, 1,0,0,0,0));

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      v = mk(1,
             ($urandom_range(0, 9) < 6), $urandom_range(0, 1), ($urandom_range(0, 9) < 4),
             32'($urandom_range(0, 15)) << 2, $urandom,
             ($urandom_range(0, 9) < 6), $urandom_range(0, 1), ($urandom_range(0, 9) < 4),
             32'($urandom_range(0, 15)) << 2, $urandom,
             0, 0, 0, 0, 0);
      if ($urandom_range(0, 99) < 2) v.rst = 1'b0;
      else if ($urandom_range(0, 99) < 1) v.rst_mid = 1'b1;
      step(v, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
